dmem_bridge: RTL and testbench
==============================

// Module: dmem_bridge
// PURPOSE
//  MEM-stage data-memory bridge: consumes the pipeline's access request (mreq_M, WRITE, BYTE_SIZE,
//  alu_out_forMem, rd2_forMem) and runs one req/ack bus transaction per access.
//  Generates byte enables and lane-replicated store data; returns right-justified, zero-filled
//  load data to DDT_from_mem (sign extension stays in the datapath).
//  Raises stall while a transaction is outstanding; flags misaligned and timed-out accesses.
// PARAMETERS
//  TIMEOUT   16  cycles bus_req may stay high without bus_ack before abort; 0 = never abort
//  CNT_W      8  width of timeout counter (TIMEOUT < 2**CNT_W)
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  mreq       in   1   access request from MEM stage (held stable by core while stall=1)
//  write      in   1   1=store, 0=load
//  byte_size  in   2   00=word, 01=half, 10=byte, 11=treated as word
//  addr       in   32  byte address
//  wdata      in   32  store data, right-justified
//  stall      out  1   hold IF..MEM pipeline registers
//  rdata      out  32  load data to datapath, right-justified, upper bits 0
//  err        out  1   1-cycle pulse: misaligned or timed-out access
//  bus_req    out  1   transaction request, held until bus_ack or abort
//  bus_we     out  1   write strobe, valid with bus_req
//  bus_addr   out  32  {addr[31:2],2'b00}
//  bus_be     out  4   byte enables, little-endian lanes
//  bus_wdata  out  32  lane-replicated store data
//  bus_ack    in   1   completion; bus_rdata valid same cycle
//  bus_rdata  in   32  raw word from memory
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0,
//   rdata=0, err=0, counter=0. Asserting reset mid-transaction drops bus_req immediately.
//  Misaligned: half with addr[0]=1, word with addr[1:0]!=0. No bus cycle is issued.
//  FSM IDLE->REQ->DONE->IDLE:
//   IDLE: mreq=1 & aligned: latch request, compute be/wdata, ->REQ; stall=1 combinationally.
//         mreq=1 & misaligned: ->DONE with err_pending=1; stall=1 this cycle.
//   REQ : bus_req=1 (registered outputs), stall=1. bus_ack=1: capture aligned load data, ->DONE.
//         Counter increments each REQ cycle without ack. When counter==TIMEOUT-1 and no ack:
//         bus_req drops next cycle, ->DONE with err_pending. mreq changes are ignored in REQ.
//   DONE: stall=0, rdata valid, err=err_pending, bus_req=0; ->IDLE unconditionally.
//  stall = (IDLE & mreq) | REQ. Minimum latency: accept cycle 0, bus_req cycle 1,
//   ack in cycle 1, DONE in cycle 2 (two stall cycles); each extra wait state adds one.
//  Back-to-back accesses: the next mreq is sampled in IDLE, one cycle after DONE.
//  Store lanes: byte be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}};
//   half be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}; word be=1111, wdata unchanged.
//  Load extract: byte (bus_rdata>>8*addr[1:0])&FF; half (bus_rdata>>16*addr[1])&FFFF;
//   word unchanged. Loads drive bus_be per size (reads ignore be). Aborted/misaligned: rdata=0.
//  rdata holds its last value outside DONE. bus_ack outside REQ is ignored.
// TESTING
//  1 LW 0x1_0008, ack 1 cycle after bus_req, bus_rdata=DEADBEEF -> bus_be=1111,
//    bus_addr=1_0008, stall 2 cycles, rdata=DEADBEEF in DONE, err=0.
//  2 SB addr=0x..03, wdata=0x000000A5 -> bus_be=1000, bus_we=1, bus_wdata=A5A5A5A5.
//  3 LH addr=0x..02, bus_rdata=0x1234ABCD, 3 wait states -> rdata=00001234, stall 5 cycles.
//  4 LW addr=0x..01 -> bus_req never rises, err pulse 1 cycle, rdata=0, stall 1 cycle.
//  5 TIMEOUT=4, no ack -> bus_req high 4 cycles then drops, err=1, stall released.
//  6 rst low during REQ -> bus_req=0 and stall=0 immediately; after release an LB completes.

Source files
------------

// File: rtl/dmem_bridge.sv
// MEM-stage data-memory bridge: turns one pipeline access into one req/ack bus transaction,
// with byte-lane steering, load extraction, stall generation and misalign/timeout reporting.
module dmem_bridge #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mreq,
    input  logic        write,
    input  logic [1:0]  byte_size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_next;
    logic              is_byte;
    logic              is_half;
    logic              misaligned;
    logic              timed_out;
    logic              err_pending;
    logic [1:0]        lane;
    logic [1:0]        size;
    logic [CNT_W-1:0]  count;
    logic [3:0]        be_calc;
    logic [31:0]       wdata_calc;
    logic [31:0]       shifted;
    logic [31:0]       load_data;

    // Lane steering for the incoming request; size 2'b11 falls through to word.
    always_comb begin
        is_byte    = (byte_size == 2'b10);
        is_half    = (byte_size == 2'b01);
        be_calc    = 4'b1111;
        wdata_calc = wdata;
        misaligned = (addr[1:0] != 2'b00);
        if (is_byte) begin
            be_calc    = 4'b0001 << addr[1:0];
            wdata_calc = {4{wdata[7:0]}};
            misaligned = 1'b0;
        end else if (is_half) begin
            be_calc    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{wdata[15:0]}};
            misaligned = addr[0];
        end
    end

    // Halves are always lane-aligned, so one shift by 8*lane serves bytes and halves.
    always_comb begin
        shifted   = bus_rdata >> {lane, 3'b000};
        load_data = bus_rdata;
        if (size == 2'b10)
            load_data = {24'h0, shifted[7:0]};
        else if (size == 2'b01)
            load_data = {16'h0, shifted[15:0]};
    end

    assign timed_out = (TIMEOUT != 0) && (count == LAST_COUNT) && !bus_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (mreq) state_next = misaligned ? DONE : REQ;
            REQ:  if (bus_ack || timed_out) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Reset gates stall so the pipeline is released the instant reset lands mid-access.
    always_comb begin
        stall = rst && (((state == IDLE) && mreq) || (state == REQ));
        err   = (state == DONE) && err_pending;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= 32'h0;
            bus_be      <= 4'h0;
            bus_wdata   <= 32'h0;
            rdata       <= 32'h0;
            err_pending <= 1'b0;
            lane        <= 2'b00;
            size        <= 2'b00;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mreq && misaligned) begin
                        err_pending <= 1'b1;
                        rdata       <= 32'h0;
                    end else if (mreq) begin
                        bus_req     <= 1'b1;
                        bus_we      <= write;
                        bus_addr    <= {addr[31:2], 2'b00};
                        bus_be      <= be_calc;
                        bus_wdata   <= wdata_calc;
                        lane        <= addr[1:0];
                        size        <= byte_size;
                        count       <= '0;
                        err_pending <= 1'b0;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        bus_we  <= 1'b0;
                        if (!bus_we)
                            rdata <= load_data;
                    end else if (timed_out) begin
                        bus_req     <= 1'b0;
                        bus_we      <= 1'b0;
                        err_pending <= 1'b1;
                        rdata       <= 32'h0;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed vector bench for dmem_bridge: a table of accesses with hand-computed bus and
// load results, plus reset, idle-ack and reset-during-transaction sequences.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        mreq;
    logic        write;
    logic [1:0]  byte_size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] last_rdata;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_data;
        int          waits;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_stall;
        int          exp_req;
    } vec_t;

    vec_t vecs[14];

    dmem_bridge #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .mreq      (mreq),
        .write     (write),
        .byte_size (byte_size),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .rdata     (rdata),
        .err       (err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One full access: drive at a negedge, sample 1ns later, ack after the requested wait states.
    task automatic apply_stimulus(input vec_t v, input logic [31:0] exp_rdata);
        int stall_cnt   = 0;
        int req_cnt     = 0;
        bit done        = 0;
        bit bus_checked = 0;
        @(negedge clk);
        mreq      = 1'b1;
        write     = v.wr;
        byte_size = v.size;
        addr      = v.addr;
        wdata     = v.wdata;
        bus_rdata = v.bus_data;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (stall) stall_cnt++;
            if (bus_req) begin
                req_cnt++;
                if (!bus_checked) begin
                    check_output($sformatf("%s.addr", v.name), bus_addr, {v.addr[31:2], 2'b00});
                    check_output($sformatf("%s.be", v.name), {28'h0, bus_be}, {28'h0, v.exp_be});
                    check_output($sformatf("%s.we", v.name), {31'h0, bus_we}, {31'h0, v.wr});
                    if (v.wr)
                        check_output($sformatf("%s.wdata", v.name), bus_wdata, v.exp_wdata);
                    bus_checked = 1;
                end
                bus_ack = (req_cnt == v.waits + 1);
            end else if (!stall && cyc > 0) begin
                check_output($sformatf("%s.err", v.name), {31'h0, err}, {31'h0, v.exp_err});
                check_output($sformatf("%s.rdata", v.name), rdata, exp_rdata);
                check_output($sformatf("%s.stall_cycles", v.name), stall_cnt, v.exp_stall);
                check_output($sformatf("%s.req_cycles", v.name), req_cnt, v.exp_req);
                mreq    = 1'b0;
                bus_ack = 1'b0;
                done    = 1;
            end
            @(negedge clk);
        end
        if (!done) begin
            check_output($sformatf("%s.completed", v.name), 32'h0, 32'h1);
            mreq    = 1'b0;
            bus_ack = 1'b0;
            @(negedge clk);
        end
        #1;
        check_output($sformatf("%s.err_pulse_end", v.name), {31'h0, err}, 32'h0);
    endtask

    initial begin
        vec_t lb;
        logic [31:0] expected;
        bit seen;

        //          name       wr    size   addr          wdata         bus_data      waits be       exp_wdata     exp_rdata     err  stall req
        vecs[0]  = '{"lw",      1'b0, 2'b00, 32'h0001_0008, 32'h0,        32'hDEADBEEF, 0,  4'b1111, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1};
        vecs[1]  = '{"sb3",     1'b1, 2'b10, 32'h0002_0003, 32'h0000_00A5, 32'h0,       0,  4'b1000, 32'hA5A5A5A5, 32'h0,        1'b0, 2, 1};
        vecs[2]  = '{"lh2_w3",  1'b0, 2'b01, 32'h0003_0002, 32'h0,        32'h1234ABCD, 3,  4'b1100, 32'h0,        32'h0000_1234, 1'b0, 5, 4};
        vecs[3]  = '{"lw_mis",  1'b0, 2'b00, 32'h0004_0001, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,        1'b1, 1, 0};
        vecs[4]  = '{"lb1_w1",  1'b0, 2'b10, 32'h0005_0001, 32'h0,        32'h11223344, 1,  4'b0010, 32'h0,        32'h0000_0033, 1'b0, 3, 2};
        vecs[5]  = '{"sh2",     1'b1, 2'b01, 32'h0006_0002, 32'hFFFFBEEF, 32'h0,        0,  4'b1100, 32'hBEEFBEEF, 32'h0,        1'b0, 2, 1};
        vecs[6]  = '{"sw_w2",   1'b1, 2'b00, 32'h0007_0004, 32'hCAFEF00D, 32'h0,        2,  4'b1111, 32'hCAFEF00D, 32'h0,        1'b0, 4, 3};
        vecs[7]  = '{"lh_mis",  1'b0, 2'b01, 32'h0008_0003, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,        1'b1, 1, 0};
        vecs[8]  = '{"sh_mis",  1'b1, 2'b01, 32'h0009_0001, 32'h0,        32'h0,        0,  4'b0000, 32'h0,        32'h0,        1'b1, 1, 0};
        vecs[9]  = '{"lw_tmo",  1'b0, 2'b00, 32'h000A_0010, 32'h0,        32'h0,        99, 4'b1111, 32'h0,        32'h0,        1'b1, 5, 4};
        vecs[10] = '{"lw_sz3",  1'b0, 2'b11, 32'h000B_000C, 32'h0,        32'h0BADF00D, 0,  4'b1111, 32'h0,        32'h0BADF00D, 1'b0, 2, 1};
        vecs[11] = '{"lb0",     1'b0, 2'b10, 32'h000C_0000, 32'h0,        32'hFFFFFF80, 0,  4'b0001, 32'h0,        32'h0000_0080, 1'b0, 2, 1};
        vecs[12] = '{"lh0",     1'b0, 2'b01, 32'h000D_0000, 32'h0,        32'h89ABCDEF, 0,  4'b0011, 32'h0,        32'h0000_CDEF, 1'b0, 2, 1};
        vecs[13] = '{"sb2",     1'b1, 2'b10, 32'h000E_0002, 32'h12345678, 32'h0,        0,  4'b0100, 32'h78787878, 32'h0,        1'b0, 2, 1};

        rst = 1'b0; mreq = 1'b0; write = 1'b0; byte_size = 2'b00;
        addr = 32'h0; wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        last_rdata = 32'h0;

        repeat (3) @(negedge clk);
        #1;
        check_output("reset.bus_req",   {31'h0, bus_req}, 32'h0);
        check_output("reset.bus_we",    {31'h0, bus_we},  32'h0);
        check_output("reset.bus_addr",  bus_addr,         32'h0);
        check_output("reset.bus_be",    {28'h0, bus_be},  32'h0);
        check_output("reset.bus_wdata", bus_wdata,        32'h0);
        check_output("reset.rdata",     rdata,            32'h0);
        check_output("reset.err",       {31'h0, err},     32'h0);
        check_output("reset.stall",     {31'h0, stall},   32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Stores leave rdata at the last load result; misaligned and aborted accesses clear it.
        foreach (vecs[i]) begin
            if (vecs[i].wr && !vecs[i].exp_err)
                expected = last_rdata;
            else
                expected = vecs[i].exp_rdata;
            apply_stimulus(vecs[i], expected);
            last_rdata = expected;
        end

        // An ack with no transaction outstanding must not disturb anything.
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_output("idle_ack.stall",   {31'h0, stall},   32'h0);
            check_output("idle_ack.bus_req", {31'h0, bus_req}, 32'h0);
            check_output("idle_ack.rdata",   rdata,            last_rdata);
        end
        bus_ack = 1'b0;

        // Reset landing while bus_req is up must drop bus_req and stall at once.
        @(negedge clk);
        mreq = 1'b1; write = 1'b0; byte_size = 2'b00; addr = 32'h0000_0100;
        seen = 0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge clk);
            #1;
            seen = bus_req;
        end
        check_output("rst_mid.req_seen", {31'h0, seen}, 32'h1);
        rst = 1'b0;
        #1;
        check_output("rst_mid.bus_req", {31'h0, bus_req}, 32'h0);
        check_output("rst_mid.stall",   {31'h0, stall},   32'h0);
        check_output("rst_mid.rdata",   rdata,            32'h0);
        mreq = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        last_rdata = 32'h0;

        lb = '{"lb_after_rst", 1'b0, 2'b10, 32'h000F_0002, 32'h0, 32'hAABBCCDD, 0,
               4'b0100, 32'h0, 32'h0000_00BB, 1'b0, 2, 1};
        apply_stimulus(lb, lb.exp_rdata);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
